// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding Avalon-MM read at a time, presents the
// fetched word to decode under valid/ready, and accepts redirects from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    input  logic        imem_readdatavalid,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        drop;

    assign imem_address = fetch_pc;
    assign imem_read    = (state == FETCH);

    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pc         <= RESET_PC;
            ir         <= NOP;
            ir_valid   <= 1'b0;
            misaligned <= 1'b0;
            drop       <= 1'b0;
        end else if (redirect && state != FAULT) begin
            ir_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned <= 1'b1;
                state      <= FAULT;
            end else begin
                fetch_pc <= redirect_pc;
                case (state)
                    FETCH: begin
                        // A read accepted this very cycle still owes us a response to discard.
                        if (!imem_waitrequest) begin
                            drop  <= 1'b1;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_readdatavalid) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (!imem_waitrequest) state <= WAIT;
                end
                WAIT: begin
                    if (imem_readdatavalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            ir       <= imem_readdata;
                            pc       <= fetch_pc;
                            ir_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        ir_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: ; // FAULT is sticky until reset
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest = 1'b0;
    logic [31:0] imem_readdata = 32'h0;
    logic        imem_readdatavalid = 1'b0;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_address      (imem_address),
        .imem_read         (imem_read),
        .imem_waitrequest  (imem_waitrequest),
        .imem_readdata     (imem_readdata),
        .imem_readdatavalid(imem_readdatavalid),
        .ir                (ir),
        .pc                (pc),
        .ir_valid          (ir_valid),
        .ir_ready          (ir_ready),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .misaligned        (misaligned)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // memory responder knobs and state
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          wr_pct = 0;
    bit          wr_block = 1'b0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    bit          stalled_now = 1'b0;
    bit          acc_now = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] last_acc = 32'h0;

    // reference model: expected fetch address, word on display, outstanding read
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] shown_pc = 32'h0;
    logic [31:0] out_addr = 32'h0;
    bit          shown = 1'b0;
    bit          outstanding = 1'b0;
    bit          live = 1'b0;
    bit          fault = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drives the memory side for the coming edge; called just after each rising edge.
    task automatic mem_drive();
        imem_readdatavalid = 1'b0;
        imem_readdata      = 32'hDEAD_BEEF;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_readdatavalid = 1'b1;
                imem_readdata      = mem_word(pend_addr);
            end
        end
        stalled_now = 1'b0;
        acc_now     = 1'b0;
        if (wr_block) begin
            imem_waitrequest = 1'b1;
        end else if (stall_left > 0 && imem_read && imem_address == stall_addr) begin
            imem_waitrequest = 1'b1;
            stall_left--;
            stalled_now = 1'b1;
        end else begin
            imem_waitrequest = (int'($urandom_range(99)) < wr_pct);
        end
        if (imem_read && !imem_waitrequest && !reset) begin
            pend_cnt  = int'($urandom_range(lat_max, lat_min));
            pend_addr = imem_address;
            acc_now   = 1'b1;
            acc_cnt++;
            last_acc  = imem_address;
        end
    endtask

    task automatic model_reset();
        exp_fetch   = RST_PC;
        shown       = 1'b0;
        outstanding = 1'b0;
        live        = 1'b0;
        fault       = 1'b0;
    endtask

    // Applies the events of the coming edge to the model (inputs are already set).
    task automatic model_edge();
        bit acc;
        acc = imem_read && !imem_waitrequest;
        if (fault) return;
        if (acc) check("acc_addr", imem_address, exp_fetch);
        if (redirect && redirect_pc[1:0] != 2'b00) begin
            fault       = 1'b1;
            shown       = 1'b0;
            outstanding = 1'b0;
            return;
        end
        if (redirect) begin
            live      = 1'b0;
            shown     = 1'b0;
            exp_fetch = redirect_pc;
        end else if (shown && ir_ready) begin
            shown     = 1'b0;
            exp_fetch = shown_pc + 32'd4;
        end
        if (imem_readdatavalid && outstanding) begin
            outstanding = 1'b0;
            if (live) begin
                shown    = 1'b1;
                shown_pc = out_addr;
            end
        end
        if (acc) begin
            outstanding = 1'b1;
            live        = !redirect;
            out_addr    = imem_address;
        end
    endtask

    task automatic model_check();
        if (fault) begin
            check("fault_misaligned", 32'(misaligned), 32'd1);
            check("fault_ir_valid", 32'(ir_valid), 32'd0);
            check("fault_read", 32'(imem_read), 32'd0);
        end else begin
            check("ir_valid", 32'(ir_valid), 32'(shown));
            if (shown) begin
                check("pc", pc, shown_pc);
                check("ir", ir, mem_word(shown_pc));
                check("hold_no_read", 32'(imem_read), 32'd0);
            end else if (outstanding) begin
                check("one_outstanding", 32'(imem_read), 32'd0);
            end
            check("misaligned", 32'(misaligned), 32'd0);
        end
    endtask

    task automatic tick();
        if (!reset) model_edge();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
        if (!reset) model_check();
    endtask

    task automatic do_reset(input int n, input bit keep_pend);
        reset    = 1'b1;
        redirect = 1'b0;
        #1;
        check("rst_read", 32'(imem_read), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir", ir, NOP);
        check("rst_pc", pc, RST_PC);
        check("rst_address", imem_address, RST_PC);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        model_reset();
        if (!keep_pend) pend_cnt = 0;
        stall_left = 0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int k = 0;
        while (!ir_valid && k < max) begin
            tick();
            k++;
        end
        check(tag, 32'(ir_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pcs [3];
        int          cycs [3];
        int          seen;
        int          c0;
        int          stall_cycles;
        int          acc104;
        bit          prev_stall;
        bit          found;
        logic [31:0] snap_pc;
        logic [31:0] first_pc;
        logic [31:0] tmp;

        #2;
        // 1: zero-wait memory, decode always ready
        do_reset(2, 1'b0);
        ir_ready = 1'b1;
        c0   = cyc;
        seen = 0;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            tick();
            if (ir_valid) begin
                pcs[seen]  = pc;
                cycs[seen] = cyc;
                seen++;
            end
        end
        check("t1_count", 32'(seen), 32'd3);
        check("t1_pc0", pcs[0], 32'h100);
        check("t1_pc1", pcs[1], 32'h104);
        check("t1_pc2", pcs[2], 32'h108);
        check("t1_latency", 32'(cycs[0] - c0), 32'd3);
        check("t1_spacing01", 32'(cycs[1] - cycs[0]), 32'd3);
        check("t1_spacing12", 32'(cycs[2] - cycs[1]), 32'd3);

        // 2: waitrequest held three cycles on 0x104
        do_reset(1, 1'b0);
        stall_addr   = 32'h104;
        stall_left   = 3;
        stall_cycles = 0;
        acc104       = 0;
        prev_stall   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (prev_stall) begin
                check("t2_read_hold", 32'(imem_read), 32'd1);
                check("t2_addr_hold", imem_address, 32'h104);
            end
            prev_stall = stalled_now;
            if (stalled_now) stall_cycles++;
            if (acc_now && last_acc == 32'h104) acc104++;
        end
        check("t2_stall_cycles", 32'(stall_cycles), 32'd3);
        check("t2_single_accept", 32'(acc104), 32'd1);

        // 3: decode back-pressure for five cycles
        ir_ready = 1'b0;
        wait_valid("t3_valid", 20);
        snap_pc = pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_valid_hold", 32'(ir_valid), 32'd1);
            check("t3_pc_hold", pc, snap_pc);
            check("t3_ir_hold", ir, mem_word(snap_pc));
            check("t3_no_read", 32'(imem_read), 32'd0);
        end
        ir_ready = 1'b1;
        tick();
        check("t3_consumed", 32'(ir_valid), 32'd0);
        wait_valid("t3_next_valid", 20);
        check("t3_next_pc", pc, snap_pc + 32'd4);

        // 4: redirect while waiting for the 0x108 response
        do_reset(1, 1'b0);
        lat_min  = 2;
        lat_max  = 2;
        ir_ready = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (acc_now && last_acc == 32'h108) found = 1'b1;
        end
        check("t4_found_108", 32'(found), 32'd1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        first_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && first_pc == 32'hFFFF_FFFF; i++) begin
            tick();
            if (ir_valid) first_pc = pc;
        end
        check("t4_first_pc", first_pc, 32'h200);
        check("t4_ir", ir, mem_word(32'h200));

        // 5: redirect and ir_ready together in HOLD
        ir_ready = 1'b0;
        wait_valid("t5_valid", 20);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        ir_ready    = 1'b1;
        tick();
        redirect = 1'b0;
        check("t5_cleared", 32'(ir_valid), 32'd0);
        wait_valid("t5_next_valid", 20);
        check("t5_pc", pc, 32'h300);
        check("t5_ir", ir, mem_word(32'h300));

        // address wrap at the top of the space
        ir_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        wait_valid("wrap_valid", 20);
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        wait_valid("wrap_next_valid", 20);
        check("wrap_zero_pc", pc, 32'h0);

        // 6: misaligned redirect is sticky until reset
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect = 1'b0;
        check("t6_misaligned", 32'(misaligned), 32'd1);
        check("t6_ir_valid", 32'(ir_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tmp         = $urandom;
            ir_ready    = tmp[0];
            redirect    = tmp[1];
            redirect_pc = {tmp[31:4], 4'h0};
            tick();
            check("t6_no_read", 32'(imem_read), 32'd0);
        end
        redirect = 1'b0;
        lat_min  = 3;
        lat_max  = 3;
        do_reset(1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (acc_now) found = 1'b1;
        end
        check("t6_restart_accept", 32'(found), 32'd1);
        check("t6_restart_addr", last_acc, RST_PC);

        // reset while the read is in flight; its late response must be ignored
        wr_block = 1'b1;
        tick();
        do_reset(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_stale_ignored", 32'(ir_valid), 32'd0);
        end
        wr_block = 1'b0;
        wait_valid("t6_fresh_valid", 20);
        check("t6_fresh_pc", pc, RST_PC);
        check("t6_fresh_ir", ir, mem_word(RST_PC));

        // randomized traffic against the model
        do_reset(2, 1'b0);
        lat_min = 1;
        lat_max = 3;
        wr_pct  = 30;
        for (int i = 0; i < 3000; i++) begin
            tmp      = $urandom;
            ir_ready = (int'($urandom_range(99)) < 70);
            redirect = (int'($urandom_range(99)) < 6);
            case ($urandom_range(3))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = {20'h0, tmp[11:2], 2'b00};
                default: redirect_pc = {tmp[31:2], 2'b00};
            endcase
            tick();
        end
        redirect = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
